id_ex_stage: RTL and testbench

//  ID/EX pipeline register of the pipelined MIPS core, directly downstream of the instruction decoder.
//  - Captures the decoder control bundle and ID operands every cycle.
//  - Detects load-use hazards and inserts bubbles.
//  - Honours downstream hold and branch/jump flush, including flushes that arrive during a hold.
//  - Drives the stall request back to the PC and IF/ID registers.

---
 rtl/id_ex_stage_if.sv | 53 +++++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Bus bundle between the ID stage and the ID/EX register: decoder fields in, EX-side fields out.
// The perf counter signals exist only when IDEX_PERF_CNT_EN is defined.
interface id_ex_if #(
  parameter int DW     = 32,
  parameter int CTRL_W = 18
`ifdef IDEX_PERF_CNT_EN
  , parameter int PERF_W = 16
`endif
);
  logic [31:0]       ir_id;
  logic [DW-1:0]     pc_id;
  logic              id_valid;
  logic [CTRL_W-1:0] ctrl_id;
  logic [DW-1:0]     rs_data_id;
  logic [DW-1:0]     rt_data_id;
  logic [DW-1:0]     imm_id;
  logic              ex_hold;
  logic              flush;

  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DW-1:0]     ex_pc;
  logic [DW-1:0]     ex_rs_data;
  logic [DW-1:0]     ex_rt_data;
  logic [DW-1:0]     ex_imm;
  logic [4:0]        ex_shamt;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_wreg;
  logic              stall_out;
`ifdef IDEX_PERF_CNT_EN
  logic [PERF_W-1:0] bubble_cnt;
  logic [PERF_W-1:0] hazard_cnt;
`endif

  modport master (
    output ir_id, pc_id, id_valid, ctrl_id, rs_data_id, rt_data_id, imm_id, ex_hold, flush,
    input  ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_shamt, ex_rs, ex_rt, ex_wreg, stall_out
`ifdef IDEX_PERF_CNT_EN
    , input bubble_cnt, hazard_cnt
`endif
  );

  modport slave (
    input  ir_id, pc_id, id_valid, ctrl_id, rs_data_id, rt_data_id, imm_id, ex_hold, flush,
    output ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_shamt, ex_rs, ex_rt, ex_wreg, stall_out
`ifdef IDEX_PERF_CNT_EN
    , output bubble_cnt, hazard_cnt
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use bubble insertion, downstream hold, and flush (also latched during hold).
// Define IDEX_PERF_CNT_EN to add saturating bubble_cnt / hazard_cnt counters.
module id_ex_stage #(
  parameter int DW     = 32,
  parameter int CTRL_W = 18
`ifdef IDEX_PERF_CNT_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  id_ex_if.slave bus
);
  localparam int CB_ALUSRC   = 17;
  localparam int CB_REGDST   = 12;
  localparam int CB_MEMWR    = 11;
  localparam int CB_MEMTOREG = 9;
  localparam int CB_REGWR    = 1;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     pc;
    logic [DW-1:0]     rs_data;
    logic [DW-1:0]     rt_data;
    logic [DW-1:0]     imm;
    logic [4:0]        shamt;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        wreg;
  } entry_t;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_FLUSH,
    ACT_HAZARD,
    ACT_LOAD
  } action_e;

  entry_t  entry_q, entry_d, id_entry;
  logic    flush_pend_q, flush_pend_d;
  action_e act;
  logic    hz;
  logic    rt_read;
  logic    stall;
  logic [4:0] id_rs, id_rt, id_rd;
  logic    unused_ir;

  assign id_rs     = bus.ir_id[25:21];
  assign id_rt     = bus.ir_id[20:16];
  assign id_rd     = bus.ir_id[15:11];
  assign unused_ir = ^{bus.ir_id[31:26], bus.ir_id[5:0]};

  // rt is a real source only for register-register ALU ops and for stores (store data).
  assign rt_read = !bus.ctrl_id[CB_ALUSRC] || bus.ctrl_id[CB_MEMWR];

  assign hz = entry_q.valid && entry_q.ctrl[CB_MEMTOREG] && entry_q.ctrl[CB_REGWR] &&
              (entry_q.wreg != 5'd0) && bus.id_valid &&
              ((entry_q.wreg == id_rs) || ((entry_q.wreg == id_rt) && rt_read));

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    id_entry         = '0;
    id_entry.valid   = bus.id_valid;
    id_entry.ctrl    = bus.id_valid ? bus.ctrl_id : '0;
    id_entry.pc      = bus.pc_id;
    id_entry.rs_data = bus.rs_data_id;
    id_entry.rt_data = bus.rt_data_id;
    id_entry.imm     = bus.imm_id;
    id_entry.shamt   = bus.ir_id[10:6];
    id_entry.rs      = id_rs;
    id_entry.rt      = id_rt;
    id_entry.wreg    = bus.ctrl_id[CB_REGDST] ? id_rd : id_rt;

    if (bus.ex_hold)                        act = ACT_HOLD;
    else if (bus.flush || flush_pend_q)     act = ACT_FLUSH;
    else if (hz)                            act = ACT_HAZARD;
    else                                    act = ACT_LOAD;

    entry_d      = entry_q;
    flush_pend_d = flush_pend_q;
    stall        = 1'b0;

    unique case (act)
      ACT_HOLD: begin
        // A flush seen while frozen must still kill the ID instruction once the hold drops.
        flush_pend_d = flush_pend_q | bus.flush;
        stall        = 1'b1;
      end
      ACT_FLUSH: begin
        entry_d      = '0;
        flush_pend_d = 1'b0;
      end
      ACT_HAZARD: begin
        entry_d = '0;
        stall   = 1'b1;
      end
      default: entry_d = id_entry;
    endcase
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.ex_valid   = entry_q.valid;
  assign bus.ex_ctrl    = entry_q.ctrl;
  assign bus.ex_pc      = entry_q.pc;
  assign bus.ex_rs_data = entry_q.rs_data;
  assign bus.ex_rt_data = entry_q.rt_data;
  assign bus.ex_imm     = entry_q.imm;
  assign bus.ex_shamt   = entry_q.shamt;
  assign bus.ex_rs      = entry_q.rs;
  assign bus.ex_rt      = entry_q.rt;
  assign bus.ex_wreg    = entry_q.wreg;
  assign bus.stall_out  = stall;

`ifdef IDEX_PERF_CNT_EN
  logic [PERF_W-1:0] bubble_cnt_q, hazard_cnt_q;
  logic              bubble_ev, hazard_ev;

  assign bubble_ev = (act == ACT_FLUSH) || (act == ACT_HAZARD);
  assign hazard_ev = (act == ACT_HAZARD);

  // Counters saturate at all-ones; a hold never produces an event, so they freeze with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hazard_cnt_q <= '0;
    end else begin
      if (bubble_ev && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + PERF_W'(1);
      if (hazard_ev && (hazard_cnt_q != '1)) hazard_cnt_q <= hazard_cnt_q + PERF_W'(1);
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.hazard_cnt = hazard_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hold/flush/reset sequences, and
// randomized traffic compared against a behavioural pipeline-register model.
module tb_id_ex_stage;
  localparam int DW     = 32;
  localparam int CTRL_W = 18;

  localparam logic [17:0] C_LW   = 18'h20202;  // alusrc, memtoreg, regwr
  localparam logic [17:0] C_R    = 18'h05002;  // aluop, regdst, regwr
  localparam logic [17:0] C_ADDI = 18'h20002;  // alusrc, regwr
  localparam logic [17:0] C_SW   = 18'h20800;  // alusrc, memwr

  localparam logic [31:0] LW8     = {6'h23, 5'd9, 5'd8, 16'h0000};
  localparam logic [31:0] LW0     = {6'h23, 5'd9, 5'd0, 16'h0000};
  localparam logic [31:0] SW8     = {6'h2b, 5'd9, 5'd8, 16'h0000};
  localparam logic [31:0] ADD10   = {6'h00, 5'd8, 5'd11, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] ADD10Z  = {6'h00, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] ADDI12  = {6'h08, 5'd8, 5'd12, 16'd4};
  localparam logic [31:0] ADDI8   = {6'h08, 5'd0, 5'd8, 16'd1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if #(.DW(DW), .CTRL_W(CTRL_W)) bus ();
  id_ex_stage #(.DW(DW), .CTRL_W(CTRL_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Model of the EX-side entry, kept as the captured instruction word plus its decoded meaning.
  logic        m_valid;
  logic [17:0] m_ctrl;
  logic [31:0] m_pc, m_rs_data, m_rt_data, m_imm, m_ir;
  logic        m_regdst;
  logic        m_pend;
  int          m_bub, m_haz;

  typedef struct {
    logic        hold;
    logic        flush;
    logic        idv;
    logic [31:0] ir;
    logic [17:0] ctrl;
    logic        exp_stall;
    logic        exp_valid;
    logic [4:0]  exp_wreg;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_dest();
    return m_regdst ? m_ir[15:11] : m_ir[20:16];
  endfunction

  function automatic bit model_hazard();
    bit is_load = m_valid && m_ctrl[9] && m_ctrl[1] && (m_dest() != 5'd0);
    bit uses_rt = !bus.ctrl_id[17] || bus.ctrl_id[11];
    return bus.id_valid && is_load &&
           ((m_dest() == bus.ir_id[25:21]) || (uses_rt && (m_dest() == bus.ir_id[20:16])));
  endfunction

  task automatic model_clear();
    m_valid = 0; m_ctrl = '0; m_pc = '0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
    m_ir = '0; m_regdst = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " ex_valid"},   bus.ex_valid,   m_valid);
    check({tag, " ex_ctrl"},    bus.ex_ctrl,    m_ctrl);
    check({tag, " ex_pc"},      bus.ex_pc,      m_pc);
    check({tag, " ex_rs_data"}, bus.ex_rs_data, m_rs_data);
    check({tag, " ex_rt_data"}, bus.ex_rt_data, m_rt_data);
    check({tag, " ex_imm"},     bus.ex_imm,     m_imm);
    check({tag, " ex_shamt"},   bus.ex_shamt,   m_ir[10:6]);
    check({tag, " ex_rs"},      bus.ex_rs,      m_ir[25:21]);
    check({tag, " ex_rt"},      bus.ex_rt,      m_ir[20:16]);
    check({tag, " ex_wreg"},    bus.ex_wreg,    m_dest());
`ifdef IDEX_PERF_CNT_EN
    check({tag, " bubble_cnt"}, bus.bubble_cnt, m_bub);
    check({tag, " hazard_cnt"}, bus.hazard_cnt, m_haz);
`endif
  endtask

  task automatic drive(input logic hold, input logic fl, input logic idv,
                       input logic [31:0] ir, input logic [17:0] ctrl);
    bus.ex_hold    = hold;
    bus.flush      = fl;
    bus.id_valid   = idv;
    bus.ir_id      = ir;
    bus.ctrl_id    = ctrl;
    bus.pc_id      = $urandom;
    bus.rs_data_id = $urandom;
    bus.rt_data_id = $urandom;
    bus.imm_id     = $urandom;
  endtask

  // One clock: check the combinational stall at negedge, advance the model at the edge,
  // then compare every registered output shortly after it.
  task automatic cycle(input string tag, output logic stall_seen);
    bit r, hold, fl, idv, hz, exp_stall;
    logic [31:0] ir, pc, rsd, rtd, imm;
    logic [17:0] ctrl;
    @(negedge clk);
    r = rst; hold = bus.ex_hold; fl = bus.flush; idv = bus.id_valid;
    ir = bus.ir_id; ctrl = bus.ctrl_id; pc = bus.pc_id;
    rsd = bus.rs_data_id; rtd = bus.rt_data_id; imm = bus.imm_id;
    hz = model_hazard();
    exp_stall = hold ? 1'b1 : ((fl || m_pend) ? 1'b0 : hz);
    stall_seen = bus.stall_out;
    if (!r) check({tag, " stall_out"}, stall_seen, exp_stall);
    @(posedge clk);
    if (r) begin
      model_clear(); m_pend = 0; m_bub = 0; m_haz = 0;
    end else if (hold) begin
      m_pend = m_pend | fl;
    end else if (fl || m_pend) begin
      model_clear(); m_pend = 0;
      if (m_bub < 65535) m_bub++;
    end else if (hz) begin
      model_clear();
      if (m_bub < 65535) m_bub++;
      if (m_haz < 65535) m_haz++;
    end else begin
      m_valid = idv; m_ctrl = idv ? ctrl : '0; m_pc = pc; m_rs_data = rsd;
      m_rt_data = rtd; m_imm = imm; m_ir = ir; m_regdst = ctrl[12];
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic st;

    tbl[0]  = '{0, 0, 1, LW8,    C_LW,   0, 1, 5'd8};
    tbl[1]  = '{0, 0, 1, ADD10,  C_R,    1, 0, 5'd0};
    tbl[2]  = '{0, 0, 1, ADD10,  C_R,    0, 1, 5'd10};
    tbl[3]  = '{0, 0, 1, LW8,    C_LW,   0, 1, 5'd8};
    tbl[4]  = '{0, 0, 1, ADDI12, C_ADDI, 1, 0, 5'd0};
    tbl[5]  = '{0, 0, 1, ADDI12, C_ADDI, 0, 1, 5'd12};
    tbl[6]  = '{0, 0, 1, LW8,    C_LW,   0, 1, 5'd8};
    tbl[7]  = '{0, 0, 1, ADDI8,  C_ADDI, 0, 1, 5'd8};
    tbl[8]  = '{0, 0, 1, LW0,    C_LW,   0, 1, 5'd0};
    tbl[9]  = '{0, 0, 1, ADD10Z, C_R,    0, 1, 5'd10};
    tbl[10] = '{0, 0, 1, LW8,    C_LW,   0, 1, 5'd8};
    tbl[11] = '{0, 0, 1, SW8,    C_SW,   1, 0, 5'd0};
    tbl[12] = '{0, 0, 1, SW8,    C_SW,   0, 1, 5'd8};
    tbl[13] = '{0, 0, 1, LW8,    C_LW,   0, 1, 5'd8};
    tbl[14] = '{0, 1, 1, ADD10,  C_R,    0, 0, 5'd0};
    tbl[15] = '{0, 0, 1, ADD10,  C_R,    0, 1, 5'd10};
    tbl[16] = '{0, 0, 0, ADD10,  C_R,    0, 0, 5'd10};

    model_clear(); m_pend = 0; m_bub = 0; m_haz = 0;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    cycle("reset0", st);
    cycle("reset1", st);
    rst = 1'b0;

    // Directed vectors: load-use, rs/rt selection, $0, store data, flush vs hazard.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].hold, tbl[i].flush, tbl[i].idv, tbl[i].ir, tbl[i].ctrl);
      cycle($sformatf("vec%0d", i), st);
      check($sformatf("vec%0d table stall", i), st, tbl[i].exp_stall);
      check($sformatf("vec%0d table valid", i), bus.ex_valid, tbl[i].exp_valid);
      check($sformatf("vec%0d table wreg", i), bus.ex_wreg, tbl[i].exp_wreg);
    end

    // Three-cycle hold with a flush in the middle cycle.
    drive(0, 0, 1, LW8, C_LW);
    cycle("hold pre", st);
    for (int c = 0; c < 3; c++) begin
      drive(1, (c == 1), 1, ADD10, C_R);
      cycle($sformatf("hold c%0d", c), st);
      check($sformatf("hold c%0d stall", c), st, 1'b1);
      check($sformatf("hold c%0d frozen valid", c), bus.ex_valid, 1'b1);
      check($sformatf("hold c%0d frozen wreg", c), bus.ex_wreg, 5'd8);
    end
    drive(0, 0, 1, ADD10, C_R);
    cycle("hold release", st);
    check("hold release stall", st, 1'b0);
    check("hold release bubble", bus.ex_valid, 1'b0);
    drive(0, 0, 1, ADD10, C_R);
    cycle("hold after", st);
    check("hold after valid", bus.ex_valid, 1'b1);
    check("hold after wreg", bus.ex_wreg, 5'd10);

    // Reset mid-stall, and reset discarding a flush latched during hold.
    drive(0, 0, 1, LW8, C_LW);
    cycle("rst pre", st);
    drive(1, 1, 1, ADD10, C_R);
    cycle("rst hold", st);
    drive(0, 0, 1, ADD10, C_R);
    rst = 1'b1;
    cycle("rst mid", st);
    check("rst mid stall before edge", st, 1'b0);
    check("rst mid cleared valid", bus.ex_valid, 1'b0);
    rst = 1'b0;
    drive(0, 0, 1, LW8, C_LW);
    cycle("rst after", st);
    check("rst after stall", st, 1'b0);
    check("rst after valid", bus.ex_valid, 1'b1);
    drive(0, 0, 1, ADD10, C_R);
    rst = 1'b1;
    cycle("rst stall", st);
    check("rst stall seen", st, 1'b1);
    check("rst stall cleared wreg", bus.ex_wreg, 5'd0);
    rst = 1'b0;
    drive(0, 0, 1, ADD10, C_R);
    cycle("rst resume", st);
    check("rst resume stall", st, 1'b0);
    check("rst resume wreg", bus.ex_wreg, 5'd10);

    // Randomized traffic with a small register pool so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ir;
      logic [17:0] ctrl;
      ir = $urandom;
      ir[25:21] = 5'($urandom_range(0, 3));
      ir[20:16] = 5'($urandom_range(0, 3));
      ir[15:11] = 5'($urandom_range(0, 3));
      ctrl = 18'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        ctrl[9] = 1'b1;
        ctrl[1] = 1'b1;
      end
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 80), ir, ctrl);
      cycle($sformatf("rand%0d", n), st);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
